// File: rtl/sun_pll_lockdet_if.sv
// Signal bundle between the PLL lock detector and its environment.
// The master side drives enable and the reference clock; the slave side is the detector.
interface sun_pll_lockdet_if #(
  parameter int CW = 8
);
  logic          EN;
  logic          CK_REF;
  logic          LOCKED;
  logic [CW-1:0] CNT;
  logic          CNT_VLD;
  logic          REF_LOST;

  modport master (
    output EN, CK_REF,
    input  LOCKED, CNT, CNT_VLD, REF_LOST
  );

  modport slave (
    input  EN, CK_REF,
    output LOCKED, CNT, CNT_VLD, REF_LOST
  );
endinterface

// File: rtl/sun_pll_lockdet.sv
// PLL lock detector: counts CK cycles per CK_REF period and asserts LOCKED after
// NLOCK consecutive in-tolerance windows, dropping it after NUNLOCK bad ones.
module sun_pll_lockdet #(
  parameter int NDIV    = 32,
  parameter int TOL     = 2,
  parameter int NLOCK   = 8,
  parameter int NUNLOCK = 2,
  parameter int CW      = 8
) (
  input  logic             CK,
  input  logic             RST_N,
  sun_pll_lockdet_if.slave bus
);

  localparam int GW = $clog2(NLOCK + 1);
  localparam int BW = $clog2(NUNLOCK + 1);
  localparam logic [CW-1:0]   PER_MAX = '1;
  localparam logic signed [CW:0] NDIV_S = (CW+1)'(NDIV);
  localparam logic signed [CW:0] TOL_S  = (CW+1)'(TOL);

  typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCK} state_t;

  logic          rst_meta_q, rst_sync_q;
  logic          ref_s1_q, ref_s2_q, ref_s3_q, ref_edge_q;
  state_t        state_q, state_d;
  logic [CW-1:0] per_q, per_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          locked_q, locked_d;
  logic          lost_q, lost_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic          per_sat;
  logic          win_good;
  logic signed [CW:0] diff;

  // Reset asserts asynchronously but releases only after two CK edges.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // CK_REF synchronizer and registered rising-edge detect; ignores EN.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      ref_s1_q   <= 1'b0;
      ref_s2_q   <= 1'b0;
      ref_s3_q   <= 1'b0;
      ref_edge_q <= 1'b0;
    end else begin
      ref_s1_q   <= bus.CK_REF;
      ref_s2_q   <= ref_s1_q;
      ref_s3_q   <= ref_s2_q;
      ref_edge_q <= ref_s2_q & ~ref_s3_q;
    end
  end

  // NOTE: the async clear makes LOCKED drop on reset with no clock running;
  // the synchronous clear holds state until the reset release has been synchronized.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      per_q    <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
    end else if (!rst_sync_q) begin
      state_q  <= IDLE;
      per_q    <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end

  assign per_sat  = (per_q == PER_MAX);
  assign diff     = $signed({1'b0, per_q}) - NDIV_S;
  assign win_good = (diff >= -TOL_S) && (diff <= TOL_S);

  // The window is judged on the ref_edge cycle so LOCKED registers together with CNT_VLD.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal (no latches).
    state_d  = state_q;
    per_d    = per_sat ? per_q : per_q + CW'(1);
    cnt_d    = cnt_q;
    vld_d    = 1'b0;
    locked_d = locked_q;
    lost_d   = lost_q;
    good_d   = good_q;
    bad_d    = bad_q;
    if (ref_edge_q) per_d = CW'(1);

    case (state_q)
      IDLE: begin
        per_d    = '0;
        cnt_d    = '0;
        locked_d = 1'b0;
        lost_d   = 1'b0;
        good_d   = '0;
        bad_d    = '0;
        if (bus.EN) state_d = ACQ;
      end
      ACQ: begin
        if (ref_edge_q) begin
          state_d = MEAS;
          lost_d  = 1'b0;
        end
      end
      MEAS: begin
        if (ref_edge_q && !per_sat) begin
          cnt_d = per_q;
          vld_d = 1'b1;
          if (!win_good) begin
            good_d = '0;
          end else if (good_q == GW'(NLOCK - 1)) begin
            state_d  = LOCK;
            locked_d = 1'b1;
            good_d   = '0;
            bad_d    = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
      end
      LOCK: begin
        if (ref_edge_q && !per_sat) begin
          cnt_d = per_q;
          vld_d = 1'b1;
          if (win_good) begin
            bad_d = '0;
          end else if (bad_q == BW'(NUNLOCK - 1)) begin
            state_d  = MEAS;
            locked_d = 1'b0;
            good_d   = '0;
            bad_d    = '0;
          end else begin
            bad_d = bad_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reference lost: an edge arriving on the saturation cycle still wins.
    if ((state_q == MEAS || state_q == LOCK) && per_sat && !ref_edge_q) begin
      state_d  = ACQ;
      lost_d   = 1'b1;
      locked_d = 1'b0;
      good_d   = '0;
      bad_d    = '0;
    end

    if (!bus.EN) begin
      state_d  = IDLE;
      per_d    = '0;
      cnt_d    = '0;
      vld_d    = 1'b0;
      locked_d = 1'b0;
      lost_d   = 1'b0;
      good_d   = '0;
      bad_d    = '0;
    end
  end

  assign bus.LOCKED   = locked_q;
  assign bus.CNT      = cnt_q;
  assign bus.CNT_VLD  = vld_q;
  assign bus.REF_LOST = lost_q;

endmodule

// File: tb/tb_sun_pll_lockdet.sv
// Self-checking bench for sun_pll_lockdet: directed tables, corner sequences and
// random CK_REF periods checked against a period-level lock model.
module tb_sun_pll_lockdet;

  localparam int NDIV    = 32;
  localparam int TOL     = 2;
  localparam int NLOCK   = 8;
  localparam int NUNLOCK = 2;
  localparam int CW      = 8;
  localparam int MAXC    = 255;

  logic CK;
  logic RST_N;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  sun_pll_lockdet_if #(.CW(CW)) bus ();

  sun_pll_lockdet #(
    .NDIV(NDIV), .TOL(TOL), .NLOCK(NLOCK), .NUNLOCK(NUNLOCK), .CW(CW)
  ) dut (
    .CK   (CK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;
  always @(posedge CK) cyc++;

  typedef struct {
    int cnt;
    bit locked;
  } exp_t;

  typedef struct {
    int period;
    int edges;
    bit exp_locked;
    int exp_cnt;
  } vec_t;

  exp_t exp_q[$];

  // Period-level reference: each CK_REF rise closes the window opened by the previous one.
  bit m_have_prev;
  int m_last_rise;
  bit m_locked;
  int m_good;
  int m_bad;
  bit lost_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_have_prev  = 1'b0;
    m_locked     = 1'b0;
    m_good       = 0;
    m_bad        = 0;
    lost_pending = 1'b0;
  endtask

  task automatic model_rise();
    int   gap;
    bit   good;
    exp_t e;
    if (m_have_prev) begin
      gap = cyc - m_last_rise;
      if (gap > MAXC) begin
        m_locked = 1'b0;
        m_good   = 0;
        m_bad    = 0;
      end else if (gap < MAXC) begin
        good = ((gap > NDIV) ? gap - NDIV : NDIV - gap) <= TOL;
        if (!m_locked) begin
          m_good = good ? m_good + 1 : 0;
          if (m_good == NLOCK) begin
            m_locked = 1'b1;
            m_bad    = 0;
          end
        end else begin
          m_bad = good ? 0 : m_bad + 1;
          if (m_bad == NUNLOCK) begin
            m_locked = 1'b0;
            m_good   = 0;
          end
        end
        e.cnt    = gap;
        e.locked = m_locked;
        exp_q.push_back(e);
      end
    end
    m_have_prev = 1'b1;
    m_last_rise = cyc;
  endtask

  // Raise CK_REF now, fall at mid-period, return at the next rise point.
  task automatic send(input int p);
    bit was_lost;
    was_lost = lost_pending;
    model_rise();
    bus.CK_REF = 1'b1;
    for (int i = 1; i <= p; i++) begin
      @(negedge CK);
      if (i == p / 2) bus.CK_REF = 1'b0;
      if (was_lost && i == 2) check("lost_hold", bus.REF_LOST, 1);
      if (was_lost && i == 6) check("lost_clear", bus.REF_LOST, 0);
      if (p > MAXC && i == 250) check("lost_early", bus.REF_LOST, 0);
      if (p > MAXC && i == p) begin
        check("lost_set", bus.REF_LOST, 1);
        check("lost_unlock", bus.LOCKED, 0);
      end
    end
    lost_pending = (p > MAXC);
  endtask

  task automatic check_zero(input string name);
    check(name, {bus.LOCKED, bus.CNT_VLD, bus.REF_LOST, bus.CNT}, 0);
  endtask

  task automatic en_cycle();
    bus.EN = 1'b0;
    @(negedge CK);
    check_zero("en_off_zero");
    repeat (2) @(negedge CK);
    bus.EN = 1'b1;
    model_clear();
    repeat (4) @(negedge CK);
  endtask

  always @(negedge CK) begin
    exp_t e;
    if (RST_N && bus.CNT_VLD) begin
      if (exp_q.size() == 0) begin
        check("vld_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("cnt", bus.CNT, e.cnt);
        check("locked_at_vld", bus.LOCKED, e.locked);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   r;
    int   p;
    vecs[0] = '{period: 32, edges: 9,  exp_locked: 1'b1, exp_cnt: 32};
    vecs[1] = '{period: 35, edges: 12, exp_locked: 1'b0, exp_cnt: 35};
    vecs[2] = '{period: 29, edges: 12, exp_locked: 1'b0, exp_cnt: 29};
    vecs[3] = '{period: 34, edges: 9,  exp_locked: 1'b1, exp_cnt: 34};
    vecs[4] = '{period: 30, edges: 9,  exp_locked: 1'b1, exp_cnt: 30};
    vecs[5] = '{period: 32, edges: 8,  exp_locked: 1'b0, exp_cnt: 32};
    vecs[6] = '{period: 36, edges: 10, exp_locked: 1'b0, exp_cnt: 36};

    model_clear();
    RST_N      = 1'b0;
    bus.EN     = 1'b1;
    bus.CK_REF = 1'b0;

    // Reset with EN high and CK_REF toggling.
    for (int i = 0; i < 8; i++) begin
      @(negedge CK);
      bus.CK_REF = ~bus.CK_REF;
      if (i == 3 || i == 7) check_zero("reset_outputs");
    end
    bus.CK_REF = 1'b0;
    repeat (3) @(negedge CK);
    RST_N = 1'b1;
    repeat (6) @(negedge CK);

    // First edge after release, then lock on the 9th edge.
    send(32);
    check("locked_first_edge", bus.LOCKED, 0);
    for (int k = 0; k < 7; k++) send(32);
    check("locked_before_8th", bus.LOCKED, 0);
    send(32);
    check("locked_after_9", bus.LOCKED, 1);

    // One bad window is tolerated, two consecutive drop lock.
    send(40);
    send(32);
    send(32);
    check("locked_one_bad", bus.LOCKED, 1);
    send(40);
    send(40);
    send(32);
    check("unlocked_two_bad", bus.LOCKED, 0);

    // Relock, stop CK_REF, restart and relock after 9 edges.
    en_cycle();
    for (int k = 0; k < 9; k++) send(32);
    check("locked_pre_stop", bus.LOCKED, 1);
    send(300);
    for (int k = 0; k < 8; k++) send(32);
    check("relock_not_yet", bus.LOCKED, 0);
    send(32);
    check("relock_after_lost", bus.LOCKED, 1);

    // EN dropped mid-window while locked.
    model_rise();
    bus.CK_REF = 1'b1;
    repeat (16) @(negedge CK);
    bus.CK_REF = 1'b0;
    bus.EN     = 1'b0;
    @(negedge CK);
    check_zero("en_drop_zero");
    repeat (3) @(negedge CK);
    bus.EN = 1'b1;
    model_clear();
    repeat (12) @(negedge CK);
    for (int k = 0; k < 8; k++) send(32);
    check("reacq_not_yet", bus.LOCKED, 0);
    send(32);
    check("reacq_locked", bus.LOCKED, 1);

    // Reset mid-lock clears LOCKED with no clock edge.
    #2;
    RST_N = 1'b0;
    #1;
    check("reset_async_unlock", bus.LOCKED, 0);
    model_clear();
    repeat (3) @(negedge CK);
    check_zero("reset_mid_zero");
    RST_N = 1'b1;
    repeat (6) @(negedge CK);

    // Directed period table.
    foreach (vecs[v]) begin
      en_cycle();
      for (int k = 0; k < vecs[v].edges; k++) send(vecs[v].period);
      check($sformatf("vec%0d_locked", v), bus.LOCKED, vecs[v].exp_locked);
      check($sformatf("vec%0d_cnt", v), bus.CNT, vecs[v].exp_cnt);
    end

    // Random periods, occasional stops and EN toggles.
    en_cycle();
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      p = $urandom_range(31, 33);
      else if (r < 75) p = $urandom_range(29, 35);
      else if (r < 85) p = $urandom_range(36, 45);
      else if (r < 90) p = $urandom_range(20, 28);
      else if (r < 95) p = 300;
      else             p = 0;
      if (p == 0) en_cycle();
      else send(p);
    end
    repeat (10) @(negedge CK);
    check("exp_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sun_pll_lockdet.md
SUN_PLL_LOCKDET -- requirements
Module: sun_pll_lockdet

Interface
REQ-001 Parameter NDIV, default 32: expected CK cycles per CK_REF period; matches the SUN_PLL_DIVN ratio.
REQ-002 Parameter TOL, default 2: allowed absolute deviation of a measured period from NDIV.
REQ-003 Parameter NLOCK, default 8: consecutive good windows needed to assert lock.
REQ-004 Parameter NUNLOCK, default 2: consecutive bad windows needed to drop lock.
REQ-005 Parameter CW, default 8: period counter and CNT width; 2^CW-1 > NDIV+TOL.
REQ-006 Port CK, input, 1: PLL output clock, from the SUN_PLL_ROSC CK pin; sole clock.
REQ-007 Port RST_N, input, 1: reset, asynchronous assert, active low.
REQ-008 Port EN, input, 1: detector enable, synchronous to CK.
REQ-009 Port CK_REF, input, 1: reference clock, asynchronous to CK.
REQ-010 Port LOCKED, output, 1: PLL lock indication.
REQ-011 Port CNT, output, CW: last measured CK_REF period in CK cycles.
REQ-012 Port CNT_VLD, output, 1: one-cycle strobe when CNT updates.
REQ-013 Port REF_LOST, output, 1: period counter saturated, no CK_REF edge seen.

Function
REQ-014 CK_REF passes through a 2-flop synchronizer, then a registered rising-edge detect; pulse ref_edge fires 3 CK cycles after the CK_REF rising edge (±1 for metastability).
REQ-015 Period counter: loads 1 on ref_edge, otherwise increments each cycle, saturating at 2^CW-1; measured period = CK cycles between consecutive ref_edge pulses.
REQ-016 States: IDLE, ACQ, MEAS, LOCK.
REQ-017 IDLE: counters cleared, all outputs 0; EN=1 -> ACQ next cycle.
REQ-018 ACQ: waits for first ref_edge; on ref_edge starts counter -> MEAS; no CNT_VLD issued.
REQ-019 MEAS/LOCK: on each ref_edge, register CNT <= counter value and pulse CNT_VLD in the following cycle.
REQ-020 Window good iff |CNT - NDIV| <= TOL, evaluated on the CNT_VLD cycle; arithmetic uses CW+1 bits signed, no wrap.
REQ-021 MEAS: good increments good_cnt, bad clears it; when good_cnt reaches NLOCK, LOCKED=1 in the same cycle as that CNT_VLD -> LOCK, bad_cnt=0.
REQ-022 LOCK: bad increments bad_cnt, good clears it; when bad_cnt reaches NUNLOCK, LOCKED=0 in the same cycle as that CNT_VLD -> MEAS, good_cnt=0.
REQ-023 Counter reaching 2^CW-1 in MEAS or LOCK: REF_LOST=1 and LOCKED=0 next cycle, good_cnt/bad_cnt cleared -> ACQ; REF_LOST held until next ref_edge, then cleared.
REQ-024 Saturated count is never reported as CNT; the first edge after REF_LOST only restarts timing.
REQ-025 EN=0 in any state: next cycle -> IDLE, all outputs and counters 0, synchronizer flops retained.
REQ-026 ref_edge coinciding with counter saturation: the edge wins, counter restarts, no REF_LOST.

Reset
REQ-027 RST_N=0 asynchronously forces IDLE, synchronizer/counters 0, LOCKED=0, CNT=0, CNT_VLD=0, REF_LOST=0.
REQ-028 RST_N release is synchronized internally; first state update occurs no earlier than the second CK edge after deassertion.
REQ-029 Reset asserted mid-LOCK drops LOCKED immediately (combinationally via flop clear), with no CK edge required.

Verification (NDIV=32, TOL=2, NLOCK=8, NUNLOCK=2, CW=8)
REQ-030 Reset with EN=1 and CK_REF toggling -> all outputs 0 during reset; LOCKED stays 0 for the first edge after release.
REQ-031 CK_REF period 32 CK -> CNT=32 on every CNT_VLD; LOCKED rises on the 8th CNT_VLD (9th CK_REF edge).
REQ-032 Period 35 (and 29) -> CNT=35 (29), LOCKED never asserts; period 34 -> locks after 8 windows.
REQ-033 Locked, one period 40 then 32 -> LOCKED stays 1; two consecutive 40 -> LOCKED falls on the second CNT_VLD.
REQ-034 Locked, CK_REF stopped -> REF_LOST=1 and LOCKED=0 about 255 cycles after the last ref_edge; restart at 32 -> REF_LOST clears on the first edge, relock after 9 more edges.
REQ-035 EN dropped mid-window while locked -> all outputs 0 the next cycle; EN restored -> full reacquisition (9 edges) before LOCKED=1.
